// File: rtl/ttl_pkg.sv
// Shared constants and helpers for the TTL-replacement counter blocks
// (ttl_edge_det, ttl_updown_counter).
package ttl_pkg;

  // Edge trackers start high so a pin already high at reset release is not an edge.
  localparam logic EDGE_RST_LVL = 1'b1;
  localparam int   SYNC_DEPTH   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ttl_edge_det.sv
// Rising-edge detector for a TTL "clock" pin sampled on mclk.
// With SYNC_IN_EN defined, the pin first passes through a SYNC_DEPTH-flop synchroniser.
module ttl_edge_det
  import ttl_pkg::*;
(
  input  logic mclk,
  input  logic rst,
  input  logic pin,
  output logic pin_edge,
  output logic pin_q
);

  logic old_q;

`ifdef SYNC_IN_EN
  logic [SYNC_DEPTH-1:0] sync_sr;

  always_ff @(posedge mclk) begin
    if (rst) sync_sr <= {SYNC_DEPTH{EDGE_RST_LVL}};
    else     sync_sr <= {sync_sr[SYNC_DEPTH-2:0], pin};
  end

  assign pin_q = sync_sr[SYNC_DEPTH-1];
`else
  assign pin_q = pin;
`endif

  // Edge tracker follows the pin every cycle, regardless of clr/load.
  always_ff @(posedge mclk) begin
    if (rst) old_q <= EDGE_RST_LVL;
    else     old_q <= pin_q;
  end

  assign pin_edge = pin_q & ~old_q;

endmodule

// File: rtl/ttl_updown_counter.sv
// 74192/74193-class up/down counter running on mclk, with TTL pins sampled as data.
// Optional macro SYNC_IN_EN adds 2-flop synchronisers on up_clk, dn_clk, load_n, clr.
module ttl_updown_counter
  import ttl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             up_clk,
  input  logic             dn_clk,
  input  logic             load_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             co_n,
  output logic             bo_n
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("ttl_updown_counter: WIDTH must be 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("ttl_updown_counter: MODULUS must be 2..2**WIDTH");
  end

  logic up_edge, dn_edge;
  logic up_lvl, dn_lvl;
  logic load_n_s, clr_s;

  ttl_edge_det u_up_det (
    .mclk     (mclk),
    .rst      (rst),
    .pin      (up_clk),
    .pin_edge (up_edge),
    .pin_q    (up_lvl)
  );

  ttl_edge_det u_dn_det (
    .mclk     (mclk),
    .rst      (rst),
    .pin      (dn_clk),
    .pin_edge (dn_edge),
    .pin_q    (dn_lvl)
  );

`ifdef SYNC_IN_EN
  logic [SYNC_DEPTH-1:0] load_sr, clr_sr;

  // Level controls get the same depth as the edge pins so all paths stay aligned.
  always_ff @(posedge mclk) begin
    if (rst) begin
      load_sr <= '1;
      clr_sr  <= '0;
    end else begin
      load_sr <= {load_sr[SYNC_DEPTH-2:0], load_n};
      clr_sr  <= {clr_sr[SYNC_DEPTH-2:0], clr};
    end
  end

  assign load_n_s = load_sr[SYNC_DEPTH-1];
  assign clr_s    = clr_sr[SYNC_DEPTH-1];
`else
  assign load_n_s = load_n;
  assign clr_s    = clr;
`endif

  // Counter core: rst > clr > load > single-direction count; both edges together hold.
  always_ff @(posedge mclk) begin
    if (rst) begin
      q <= RST_Q;
    end else if (clr_s) begin
      q <= '0;
    end else if (!load_n_s) begin
      q <= d;
    end else if (up_edge && !dn_edge) begin
      q <= (q >= MAX_Q) ? '0 : q + 1'b1;
    end else if (dn_edge && !up_edge) begin
      q <= (q == '0) ? MAX_Q : q - 1'b1;
    end
  end

  // Carry/borrow are gated by the live pin level to reproduce the TTL pulse for cascading.
  assign co_n = !((q == MAX_Q) && !up_lvl);
  assign bo_n = !((q == '0) && !dn_lvl);

endmodule
